// File: rtl/branch_resolver.sv
// branch_resolver: execute-stage branch evaluation, misprediction redirect/flush and statistics.
`ifndef BR_DEFS
`define BR_DEFS
`define WORD_T logic [31:0]
`define OPER_T logic [3:0]
`define OP_BEQ  4'd0
`define OP_BNE  4'd1
`define OP_BLT  4'd4
`define OP_BGE  4'd5
`define OP_BLTU 4'd6
`define OP_BGEU 4'd7
`endif

module branch_resolver #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  `OPER_T           in_op,
    input  `WORD_T           in_pc,
    input  `WORD_T           in_imm,
    input  `WORD_T           in_rs1_data,
    input  `WORD_T           in_rs2_data,
    input  logic             in_pred_taken,
    output logic             res_valid,
    output logic             res_taken,
    output `WORD_T           res_target,
    output logic             redirect_valid,
    output `WORD_T           redirect_pc,
    input  logic             redirect_ready,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispredict_count
);
    typedef enum logic {IDLE, REDIRECT} state_t;
    state_t state, state_nx;
    logic is_br, taken, eq, slt, ult, br_acc, mis;
    `WORD_T target, fallthrough;

    always_comb begin
        eq = in_rs1_data == in_rs2_data;
        slt = $signed(in_rs1_data) < $signed(in_rs2_data);
        ult = in_rs1_data < in_rs2_data;
        is_br = in_op inside {`OP_BEQ, `OP_BNE, `OP_BLT, `OP_BGE, `OP_BLTU, `OP_BGEU};
        taken = (in_op == `OP_BEQ)  ? eq   :
                (in_op == `OP_BNE)  ? !eq  :
                (in_op == `OP_BLT)  ? slt  :
                (in_op == `OP_BGE)  ? !slt :
                (in_op == `OP_BLTU) ? ult  :
                (in_op == `OP_BGEU) ? !ult : 1'b0;
        target = in_pc + in_imm;
        fallthrough = in_pc + 32'd4;
        in_ready = state == IDLE;
        redirect_valid = state == REDIRECT;
        br_acc = in_valid && in_ready && is_br;
        mis = br_acc && (taken != in_pred_taken);
        state_nx = (state == IDLE) ? (mis ? REDIRECT : IDLE) : (redirect_ready ? IDLE : REDIRECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_taken <= 1'b0;
            res_target <= '0;
            redirect_pc <= '0;
            flush <= 1'b0;
            br_count <= '0;
            mispredict_count <= '0;
        end else begin
            res_valid <= br_acc;
            flush <= mis;
            if (br_acc) begin
                res_taken <= taken;
                res_target <= target;
                br_count <= br_count + 1'b1;
            end
            // redirect_pc only changes on a mispredict, so it stays stable throughout REDIRECT
            if (mis) begin
                redirect_pc <= taken ? target : fallthrough;
                mispredict_count <= mispredict_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed and randomized checks of branch_resolver against a behavioural model.
`ifndef BR_DEFS
`define BR_DEFS
`define WORD_T logic [31:0]
`define OPER_T logic [3:0]
`define OP_BEQ  4'd0
`define OP_BNE  4'd1
`define OP_BLT  4'd4
`define OP_BGE  4'd5
`define OP_BLTU 4'd6
`define OP_BGEU 4'd7
`endif

module tb_branch_resolver;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready, in_pred_taken = 0, redirect_ready = 0;
    `OPER_T in_op = 4'd2;
    `WORD_T in_pc = 0, in_imm = 0, in_rs1_data = 0, in_rs2_data = 0;
    logic res_valid, res_taken, redirect_valid, flush;
    `WORD_T res_target, redirect_pc;
    logic [31:0] br_count, mispredict_count;
    int checks = 0, errors = 0;

    bit m_redir, m_rv, m_rt, m_fl;
    logic [31:0] m_tgt, m_rpc, m_br, m_mis;

    always #5 clk = ~clk;

    branch_resolver #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_pred_taken(in_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
        .res_target(res_target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush(flush), .br_count(br_count),
        .mispredict_count(mispredict_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int branch_kind(input logic [3:0] op);
        case (op)
            `OP_BEQ: return 1;
            `OP_BNE: return 2;
            `OP_BLT: return 3;
            `OP_BGE: return 4;
            `OP_BLTU: return 5;
            `OP_BGEU: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_taken(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int sx = int'(x), sy = int'(y);
        longint ux = longint'({32'd0, x}), uy = longint'({32'd0, y});
        case (branch_kind(op))
            1: return x == y;
            2: return x != y;
            3: return sx < sy;
            4: return sx >= sy;
            5: return ux < uy;
            6: return ux >= uy;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_redir = 0; m_rv = 0; m_rt = 0; m_fl = 0;
        m_tgt = 0; m_rpc = 0; m_br = 0; m_mis = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_redir));
        chk({tag, ".res_valid"}, 32'(res_valid), 32'(m_rv));
        chk({tag, ".res_taken"}, 32'(res_taken), 32'(m_rt));
        chk({tag, ".res_target"}, res_target, m_tgt);
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(m_redir));
        chk({tag, ".redirect_pc"}, redirect_pc, m_rpc);
        chk({tag, ".flush"}, 32'(flush), 32'(m_fl));
        chk({tag, ".br_count"}, br_count, m_br);
        chk({tag, ".mispredict_count"}, mispredict_count, m_mis);
    endtask

    // Advance one clock, predicting the post-edge outputs from the inputs currently driven.
    task automatic step(input string tag);
        bit acc, tk, nredir;
        acc = in_valid && !m_redir;
        nredir = m_redir && !redirect_ready;
        m_rv = 0; m_fl = 0;
        if (acc && branch_kind(in_op) != 0) begin
            tk = ref_taken(in_op, in_rs1_data, in_rs2_data);
            m_rv = 1; m_rt = tk; m_tgt = in_pc + in_imm; m_br++;
            if (tk != in_pred_taken) begin
                m_mis++; m_fl = 1; nredir = 1;
                m_rpc = tk ? in_pc + in_imm : in_pc + 32'd4;
            end
        end
        m_redir = nredir;
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] x, input logic [31:0] y, input bit pred);
        in_valid = 1; in_op = op; in_pc = pc; in_imm = imm;
        in_rs1_data = x; in_rs2_data = y; in_pred_taken = pred;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 0;

        drive(`OP_BEQ, 32'h100, 32'h20, 5, 5, 0);
        step("beq_mis");
        chk("beq.res_target", res_target, 32'h120);
        chk("beq.redirect_pc", redirect_pc, 32'h120);
        in_valid = 0; redirect_ready = 1;
        step("beq_hs");
        redirect_ready = 0;

        drive(`OP_BLT, 32'h200, 32'h40, 32'hFFFFFFFF, 1, 1);
        step("blt_taken");
        chk("blt.res_taken", 32'(res_taken), 1);
        drive(`OP_BLTU, 32'h300, 32'h40, 32'hFFFFFFFF, 1, 1);
        step("bltu_mis");
        chk("bltu.redirect_pc", redirect_pc, 32'h304);
        in_valid = 0; redirect_ready = 1;
        step("bltu_hs");
        redirect_ready = 0;

        drive(`OP_BNE, 32'hFFFFFFF0, 32'h20, 1, 2, 0);
        step("bne_wrap");
        chk("bne.res_target", res_target, 32'h10);
        chk("bne.redirect_pc", redirect_pc, 32'h10);
        for (int i = 0; i < 3; i++) step("redir_hold");
        redirect_ready = 1;
        step("redir_hs");
        redirect_ready = 0; in_valid = 0;
        step("idle_after");

        drive(4'd9, 32'h400, 32'h8, 3, 3, 1);
        step("nonbranch");
        for (int i = 0; i < 4; i++) begin
            drive(`OP_BGEU, 32'h500 + 32'(i * 4), 32'h10, 32'(i + 7), 32'(i), 1);
            step("bgeu_b2b");
        end
        in_valid = 0;
        step("bgeu_done");

        drive(`OP_BEQ, 32'h600, 32'h8, 1, 2, 1);
        step("pre_rst_mis");
        in_valid = 0;
        #2 rst = 1;
        #1;
        model_reset();
        check_all("rst_async");
        #1 rst = 0;
        drive(`OP_BEQ, 32'h700, 32'hC, 9, 9, 1);
        step("post_rst_accept");
        chk("post_rst.br_count", br_count, 1);

        for (int i = 0; i < 400; i++) begin
            if (!m_redir) begin
                logic [31:0] x;
                x = $urandom;
                drive(4'($urandom_range(0, 9)), $urandom & 32'hFFFFFFFC,
                      ($urandom_range(0, 1) ? 32'hFFFFF000 : 32'h0) | ($urandom & 32'hFFE),
                      x, $urandom_range(0, 3) == 0 ? x : $urandom, 1'($urandom));
                in_valid = 1'($urandom_range(0, 3) != 0);
            end
            redirect_ready = 1'($urandom_range(0, 2) == 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
